// File: rtl/booth_pe_mac.sv
// Weight-stationary signed MAC cell with a radix-4 Booth sequential multiplier; result valid NITER+1 edges after accept, held until out_ready.
// Ingress stalls (in_ready=0) while busy or training; optional accumulator clamping with BOOTH_PE_ACC_SAT_EN, otherwise the sum wraps.
module booth_pe_mac #(
  parameter int ROW_NO    = 0,
  parameter int COLUMN_NO = 0,
  parameter int DATAWIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst_overall,
  input  logic                     rst_vals,
  input  logic                     train_en,
  input  logic [DATAWIDTH-1:0]     weight_update,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATAWIDTH-1:0]     value,
  input  logic [2*DATAWIDTH-1:0]   inp_west,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*DATAWIDTH-1:0]   outp_east,
  output logic                     sat_flag,
  output logic                     busy
);

  localparam int ACCW  = 2 * DATAWIDTH;
  localparam int NITER = (DATAWIDTH + 1) / 2;
  localparam int MW    = 2 * NITER;
  localparam int CW    = $clog2(NITER + 1);

  if (DATAWIDTH < 4 || DATAWIDTH > 32 || ROW_NO < 0 || COLUMN_NO < 0) begin : g_bad_param
    $error("booth_pe_mac: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [DATAWIDTH-1:0]  weight_q, weight_d;
  logic [ACCW-1:0]       mc_q, mc_d;
  logic [MW-1:0]         mplier_q, mplier_d;
  logic                  prev_q, prev_d;
  logic [ACCW-1:0]       pp_q, pp_d;
  logic [ACCW-1:0]       west_q, west_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ACCW-1:0]       out_q, out_d;
  logic                  ovld_q, ovld_d;
  logic                  sat_q, sat_d;

  logic [DATAWIDTH:0]    wsum;
  logic [DATAWIDTH-1:0]  wclamp;
  logic [2:0]            grp;
  logic [ACCW-1:0]       mc2;
  logic [ACCW-1:0]       booth_pp;
  logic [ACCW-1:0]       acc_res;
  logic                  acc_sat;

  assign wsum = {weight_q[DATAWIDTH-1], weight_q} + {weight_update[DATAWIDTH-1], weight_update};

  always_comb begin
    wclamp = wsum[DATAWIDTH-1:0];
    if (wsum[DATAWIDTH] != wsum[DATAWIDTH-1]) begin
      wclamp = wsum[DATAWIDTH] ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
    end
  end

  // Booth group: two multiplier bits plus the bit shifted out last cycle.
  assign grp = {mplier_q[1:0], prev_q};
  assign mc2 = mc_q << 1;

  always_comb begin
    booth_pp = '0;
    case (grp)
      3'b001, 3'b010: booth_pp = mc_q;
      3'b011:         booth_pp = mc2;
      3'b100:         booth_pp = -mc2;
      3'b101, 3'b110: booth_pp = -mc_q;
      default:        booth_pp = '0;
    endcase
  end

`ifdef BOOTH_PE_ACC_SAT_EN
  logic [ACCW:0] acc_sum;
  assign acc_sum = {pp_q[ACCW-1], pp_q} + {west_q[ACCW-1], west_q};
  assign acc_sat = acc_sum[ACCW] ^ acc_sum[ACCW-1];
  always_comb begin
    acc_res = acc_sum[ACCW-1:0];
    if (acc_sat) begin
      acc_res = acc_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
  end
`else
  assign acc_res = pp_q + west_q;
  assign acc_sat = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    weight_d = weight_q;
    mc_d     = mc_q;
    mplier_d = mplier_q;
    prev_d   = prev_q;
    pp_d     = pp_q;
    west_d   = west_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    ovld_d   = ovld_q;
    sat_d    = sat_q;
    if (rst_vals) begin
      state_d  = S_IDLE;
      mc_d     = '0;
      mplier_d = '0;
      prev_d   = 1'b0;
      pp_d     = '0;
      west_d   = '0;
      cnt_d    = '0;
      out_d    = '0;
      ovld_d   = 1'b0;
      sat_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (train_en) begin
            weight_d = wclamp;
          end else if (in_valid) begin
            mc_d     = ACCW'($signed(weight_q));
            mplier_d = MW'($signed(value));
            prev_d   = 1'b0;
            pp_d     = '0;
            west_d   = inp_west;
            cnt_d    = CW'(NITER - 1);
            state_d  = S_MUL;
          end
        end
        S_MUL: begin
          pp_d     = pp_q + booth_pp;
          mc_d     = mc_q << 2;
          mplier_d = mplier_q >> 2;
          prev_d   = mplier_q[1];
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_ACC;
        end
        S_ACC: begin
          out_d   = acc_res;
          sat_d   = acc_sat;
          ovld_d  = 1'b1;
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            ovld_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state_q  <= S_IDLE;
      weight_q <= '0;
      mc_q     <= '0;
      mplier_q <= '0;
      prev_q   <= 1'b0;
      pp_q     <= '0;
      west_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      ovld_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      weight_q <= weight_d;
      mc_q     <= mc_d;
      mplier_q <= mplier_d;
      prev_q   <= prev_d;
      pp_q     <= pp_d;
      west_q   <= west_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ovld_q   <= ovld_d;
      sat_q    <= sat_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !train_en;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ovld_q;
  assign outp_east = out_q;
  assign sat_flag  = sat_q;

endmodule
